// File: rtl/s2p_receiver_pkg.sv
// rtl/s2p_receiver_pkg.sv - shared widths, state encoding and frame length rule for the serial link
package s2p_receiver_pkg;

  localparam int WIDTH = 16;
  localparam int LEN_W = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A length field of zero encodes a full-width frame.
  function automatic logic [CNT_W-1:0] frame_len(input logic [LEN_W-1:0] len_v);
    return (len_v == '0) ? CNT_W'(WIDTH) : CNT_W'(len_v);
  endfunction

endpackage

// File: rtl/s2p_outbuf.sv
// rtl/s2p_outbuf.sv - single-entry valid/ready word buffer with sticky overrun flag
module s2p_outbuf
  import s2p_receiver_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (load_i) begin
      // A held word that is not being taken wins over the new one.
      if (valid_q && !ready_i) begin
        overrun_q <= 1'b1;
      end else begin
        data_q  <= word_i;
        valid_q <= 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/s2p_receiver.sv
// rtl/s2p_receiver.sv - MSB-first serial-to-parallel frame receiver with buffered word output
module s2p_receiver
  import s2p_receiver_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic [LEN_W-1:0] len,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q;
  logic             en_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] shreg_q;

  logic [CNT_W-1:0] n_d;
  logic [WIDTH-1:0] bit_d;
  logic [WIDTH-1:0] word_d;
  logic             complete_d;

  // The line lags enable by one cycle, so en_q qualifies the current line bit.
  always_comb begin
    n_d        = frame_len(len);
    bit_d      = {data_in, {(WIDTH-1){1'b0}}} >> cnt_q;
    word_d     = shreg_q | bit_d;
    complete_d = 1'b0;
    if (en_q) begin
      if (state_q == ST_IDLE) begin
        complete_d = (n_d == CNT_W'(1));
      end else begin
        complete_d = ((cnt_q + CNT_W'(1)) == n_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      shreg_q <= '0;
    end else begin
      en_q <= enable;
      case (state_q)
        ST_IDLE: begin
          if (en_q) begin
            n_q <= n_d;
            if (complete_d) begin
              shreg_q <= '0;
              cnt_q   <= '0;
            end else begin
              shreg_q <= bit_d;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (!en_q || complete_d) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            shreg_q <= word_d;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);

  s2p_outbuf u_outbuf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (complete_d),
    .word_i    (word_d),
    .ready_i   (ready),
    .data_o    (data_out),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

endmodule
